// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU register-file blocks.
//   DEF_XLEN  - default register width
//   DEF_DEPTH - default register count
//   REG_AW    - register-address width for the default register count
//   ZERO_IDX  - index of the hard-wired zero register
package cpu_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 32;
  localparam int REG_AW    = $clog2(DEF_DEPTH);
  localparam int ZERO_IDX  = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file.
//   rd_addr/rd_data/rd_busy   - NRP packed read ports (decode)
//   we/wr_addr/wr_data        - writeback write port
//   issue_valid/issue_addr    - destination of the instruction issuing now
//   flush                     - clear every pending bit
// master: pipeline side; slave: register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                flush;

  modport master (
    output rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, issue_valid, issue_addr, flush,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised CPU register file with per-register pending
// (scoreboard) bits for RAW-hazard detection.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (registers and pending bits to 0)
//   bus - regfile_sb_if.slave: NRP combinational read ports with busy,
//         writeback write port, issue port and flush
// The interface instance must be built with matching XLEN, AW and NRP.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NRP      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;

  logic wrEn;
  logic issueEn;

  // Gated by rst so that nothing is forwarded while reset holds the
  // outputs at zero.
  assign wrEn    = bus.we && !rst && !(ZERO_REG && bus.wr_addr == ZERO_ADDR);
  assign issueEn = bus.issue_valid && !(ZERO_REG && bus.issue_addr == ZERO_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wrEn) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // The issue assignment comes last so it overrides a same-register
  // writeback clear: the newer instruction owns the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (bus.flush) begin
      pending <= '0;
    end else begin
      if (wrEn) begin
        pending[bus.wr_addr] <= 1'b0;
      end
      if (issueEn) begin
        pending[bus.issue_addr] <= 1'b1;
      end
    end
  end

  logic [NRP*XLEN-1:0] rdDataVec;
  logic [NRP-1:0]      rdBusyVec;

  for (genvar i = 0; i < NRP; i++) begin : gRead
    logic [AW-1:0] addr;
    logic          isZero;
    logic          bypassHit;

    assign addr      = bus.rd_addr[i*AW +: AW];
    assign isZero    = ZERO_REG && (addr == ZERO_ADDR);
    assign bypassHit = BYPASS && wrEn && (bus.wr_addr == addr);

    assign rdDataVec[i*XLEN +: XLEN] = isZero    ? '0 :
                                       bypassHit ? bus.wr_data :
                                                   regs[addr];
    // Bypassed data is valid now, so the port is not busy.
    assign rdBusyVec[i] = !isZero && !bypassHit && pending[addr];
  end

  assign bus.rd_data = rdDataVec;
  assign bus.rd_busy = rdBusyVec;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 2-read/1-write CPU register file: configurable XLEN, depth and read-port count, plus a hard-wired zero register and an optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit: set when an instruction issues with that destination, cleared at writeback. The decode stage uses it to detect RAW hazards.
- Sits between decode (read ports, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers; must be a power of two, >= 2.
- NRP, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- Derived constant AW = $clog2(DEPTH).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- rd_addr, input, NRP*AW, read addresses; port i occupies bits [i*AW +: AW].
- rd_data, output, NRP*XLEN, read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy, output, NRP, port i's register has a pending write.
- we, input, 1, writeback write enable.
- wr_addr, input, AW, writeback destination.
- wr_data, input, XLEN, writeback data.
- issue_valid, input, 1, an instruction with a destination issues this cycle.
- issue_addr, input, AW, destination of the issuing instruction.
- flush, input, 1, clear all pending bits (pipeline flush).

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - all DEPTH registers go to 0 and all pending bits go to 0.
  - rd_data therefore reads 0 and rd_busy reads 0 while rst is high.
  - Writes, issues and flushes are ignored while rst is high.
- Read path: combinational, zero latency.
  - rd_data[i] = regs[rd_addr[i]].
  - If ZERO_REG and rd_addr[i]==0, rd_data[i]=0 regardless of any write.
- Bypass (BYPASS=1): if we=1, wr_addr==rd_addr[i], and the address is not the zero register, then rd_data[i]=wr_data in the same cycle.
  - With BYPASS=0 the old value is read until the edge.
- Write: on the rising clk edge with we=1, regs[wr_addr] <= wr_data.
  - Dropped when ZERO_REG and wr_addr==0.
- Pending bits update on each rising edge, in this priority order:
  1. flush=1: all bits cleared; issue and writeback-clear are ignored that cycle, but the data write still occurs.
  2. Else, if issue_valid=1 and the issue address is not the zero register: pending[issue_addr] <= 1.
  3. Writeback clear: if we=1 (and not the zero register), pending[wr_addr] <= 0, unless the same register is being set by item 2 that cycle. Issue wins, because the newer instruction owns the register.
  - Issue and write to different addresses in the same cycle: both take effect.
- rd_busy[i]:
  - = pending[rd_addr[i]] when BYPASS=0.
  - When BYPASS=1, forced to 0 if a bypassing write to that address is active this cycle, since the data is valid now.
  - Always 0 for the zero register when ZERO_REG=1.
- Multiple read ports may read the same address; each must return identical data and busy.
- Addresses are always in range (DEPTH is a power of two); no out-of-range handling.

Decomposition:
- Shared package cpu_pkg holds:
  - default XLEN and register count (32/32);
  - the register-address width constant;
  - the localparam for the zero-register index.
- No sub-module; the read mux is a generate loop over NRP.
- If a second scoreboard user appears, the pending-bit array may later move to a separate reg_scoreboard module.

Test Plan:
1. Reset then read: assert rst, release; rd_addr={4,3} -> rd_data={0,0}, rd_busy=2'b00.
2. Write/read, BYPASS=1:
   - we=1, wr_addr=3, wr_data=145 with rd_addr port0=3 -> rd_data[0]=145 in the same cycle.
   - After the edge with we=0 -> still 145.
   - Repeat with BYPASS=0 -> 0 before the edge, 145 after.
3. Zero register: we=1, wr_addr=0, wr_data=5653, issue_valid=1, issue_addr=0 -> reading x0 gives 0 with rd_busy=0 before and after the edge.
4. Scoreboard:
   - issue_addr=8 -> rd_busy for x8 is 1 from the next cycle.
   - Then we=1, wr_addr=8, wr_data=127 -> busy=0 and data=127 in that cycle (bypass), and after the edge.
5. Simultaneous events and flush:
   - x4 pending; same cycle issue_addr=4 and we to x4 with 137 -> after the edge x4=137, busy=1.
   - Then flush=1 with issue_addr=9 -> after the edge all busy=0, including x9.
6. Async reset mid-operation: x3=145, x4 pending; assert rst between edges -> rd_data=0 and rd_busy=0 immediately, without waiting for a clk edge.
